qed_imem_writer: RTL and testbench
==================================

Name: qed_imem_writer

Overview:
- Sits directly downstream of the QED instruction module and drives the write port (port A) of the instruction RAM.
- Buffers QED-emitted instructions in a small FIFO.
- Writes them into consecutive instruction-memory words, one per cycle.
- Holds off any write that would overwrite the word the core is currently fetching (core I_ADDR).

Parameters:
- DEPTH, 32, instruction RAM depth in 32-bit words; power of two; AW = log2(DEPTH).
- FIFO_DEPTH, 4, instruction buffer entries; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of instruction RAM word 0; word aligned.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; one clock, reset is synchronous and active-high.
- qed_vld_i  input  1  QED instruction valid.
- qed_instr_i  input  32  QED instruction word.
- qed_rdy_o  output  1  FIFO can accept a push this cycle.
- fetch_addr_i  input  32  core fetch byte address (I_ADDR).
- mem_addr_o  output  32  instruction RAM write byte address.
- mem_data_o  output  32  instruction RAM write data.
- mem_w_en_o  output  1  instruction RAM write enable (all byte lanes).
- wr_count_o  output  32  total words written; saturates at 32'hFFFF_FFFF.
- overflow_o  output  1  sticky flag: a valid instruction arrived while the FIFO was full.
- done_o  output  1  last RAM word written; no-wrap build only, otherwise tied 0.

Behaviour:
Reset (rst_i=1 at clk_i edge):
- FIFO empty, wr_idx=0, state IDLE.
- mem_w_en_o=0, mem_addr_o=BASE_ADDR, mem_data_o=0.
- wr_count_o=0, overflow_o=0, done_o=0, qed_rdy_o=1.
- Reset mid-burst discards buffered entries; no write is issued in the reset cycle or the cycle after.

Push:
- qed_rdy_o = (fifo_count != FIFO_DEPTH) && !done_o; combinational from registered state.
- Push occurs when qed_vld_i && qed_rdy_o.
- qed_vld_i while !qed_rdy_o: word dropped, overflow_o set to 1 and held until reset.
- A pop in the same cycle does not make a full FIFO accept a push.

Hazard:
- fetch_idx = (fetch_addr_i - BASE_ADDR) >> 2, truncated to AW bits.
- hazard = (wr_idx == fetch_idx).

Pop / write:
- A pop occurs when the FIFO is non-empty, !hazard, and state != DONE.
- On pop, the next edge registers: mem_w_en_o=1, mem_data_o=head, mem_addr_o=BASE_ADDR + (wr_idx<<2).
- Then wr_idx increments and wr_count_o increments (saturating).
- Otherwise mem_w_en_o=0; mem_addr_o and mem_data_o hold their last values.
- Throughput: one word per cycle.
- Latency: a word pushed at edge N appears on the write port after edge N+1 when no hazard.
- Simultaneous push and pop: both occur and fifo_count is unchanged.
- Empty FIFO plus push: the pushed word is not popped until the following cycle (no bypass).

FSM, evaluated each edge in priority order:
- IDLE: FIFO empty; go to WRITE when fifo_count becomes non-zero.
- WRITE: pop each cycle; go to BLOCKED if hazard with FIFO non-empty; go to IDLE when the last entry is popped and no push occurs.
- BLOCKED: no pop; return to WRITE when hazard clears.
- DONE: no-wrap build only; terminal until reset.

Wrap-around: wr_idx = DEPTH-1 followed by a pop; behaviour is set by the optional feature below.

Optional Feature:
QED_IMEM_WRAP_EN:
- Defined: wr_idx wraps from DEPTH-1 to 0 and writing continues indefinitely; done_o is tied 0; the DONE state does not exist.
- Undefined:
  - The pop at wr_idx = DEPTH-1 moves to DONE and sets done_o=1, sticky.
  - qed_rdy_o is forced to 0, so further qed_vld_i sets overflow_o.
  - Remaining FIFO entries are retained but never written.

Test Plan:
- Reset release, fetch_addr_i=32'h40, push 32'h0000_0013 at edge 3 -> mem_w_en_o=1 after edge 4, mem_addr_o=32'h0, mem_data_o=32'h13, wr_count_o=1.
- Push 6 words back-to-back with FIFO_DEPTH=4 and fetch_addr_i=32'h40 -> all 6 written at addresses 0x0..0x14 on consecutive cycles, overflow_o=0.
- fetch_addr_i=32'h8 with 3 words queued -> writes to 0x0 and 0x4, then mem_w_en_o=0 held; change fetch_addr_i to 32'h20 -> third word written at 0x8 the next cycle.
- Hold fetch_addr_i=32'h0 (permanent hazard) and push 5 words -> first 4 accepted, 5th dropped with qed_rdy_o=0, overflow_o=1, no writes.
- Without QED_IMEM_WRAP_EN, write 32 words -> last write at 0x7C, done_o=1, qed_rdy_o=0. With the macro, word 33 is written at 0x0.
- Assert rst_i for one cycle with 3 words queued -> no write for 2 cycles, wr_count_o=0. A subsequent push is written at 0x0.

Source files
------------

// File: rtl/qed_imem_writer.sv
// Buffers QED instructions in a small FIFO and streams them into consecutive instruction-RAM
// words on port A, holding off writes to the word the core is fetching. Macro: QED_IMEM_WRAP_EN.
module qed_imem_writer #(
  parameter int          DEPTH      = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        qed_vld_i,
  input  logic [31:0] qed_instr_i,
  output logic        qed_rdy_o,
  input  logic [31:0] fetch_addr_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_w_en_o,
  output logic [31:0] wr_count_o,
  output logic        overflow_o,
  output logic        done_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [FAW:0]  FULL_CNT = FIFO_DEPTH[FAW:0];
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

`ifdef QED_IMEM_WRAP_EN
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_BLOCKED} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_BLOCKED, S_DONE} state_t;
`endif

  state_t        state_q, state_d;
  logic [31:0]   fifo_mem_q [FIFO_DEPTH];
  logic [FAW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FAW:0]  count_q, count_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_data_q, mem_data_d;
  logic          mem_w_en_q, mem_w_en_d;
  logic [31:0]   wr_count_q, wr_count_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;

  logic [31:0]   fetch_off;
  logic [AW-1:0] fetch_idx;
  logic          hazard, push, pop, fifo_empty, pop_last;
  logic          unused_fetch_bits;

  assign fetch_off = fetch_addr_i - BASE_ADDR;
  assign fetch_idx = fetch_off[AW+1:2];
  assign unused_fetch_bits = &{1'b0, fetch_off[31:AW+2], fetch_off[1:0]};
  assign hazard    = (wr_idx_q == fetch_idx);

  assign fifo_empty = (count_q == '0);
  assign qed_rdy_o  = (count_q != FULL_CNT) && !done_q;
  assign push       = qed_vld_i && qed_rdy_o;
  assign pop        = !fifo_empty && !hazard && !done_q;
`ifdef QED_IMEM_WRAP_EN
  assign pop_last   = 1'b0;
`else
  assign pop_last   = pop && (wr_idx_q == LAST_IDX);
`endif

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    wr_idx_d   = wr_idx_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_w_en_d = 1'b0;
    wr_count_d = wr_count_q;
    overflow_d = overflow_q | (qed_vld_i & ~qed_rdy_o);
    done_d     = done_q | pop_last;
    state_d    = state_q;

    if (push) wr_ptr_d = wr_ptr_q + FAW'(1);
    if (push && !pop)      count_d = count_q + (FAW+1)'(1);
    else if (pop && !push) count_d = count_q - (FAW+1)'(1);

    if (pop) begin
      mem_w_en_d = 1'b1;
      mem_data_d = fifo_mem_q[rd_ptr_q];
      mem_addr_d = BASE_ADDR + {{(30-AW){1'b0}}, wr_idx_q, 2'b00};
      rd_ptr_d   = rd_ptr_q + FAW'(1);
      wr_idx_d   = wr_idx_q + AW'(1);
      if (wr_count_q != 32'hFFFF_FFFF) wr_count_d = wr_count_q + 32'd1;
    end

    // Next state is bookkeeping; pops are governed only by FIFO occupancy, hazard and done.
    case (state_q)
      S_IDLE:
        if (pop_last)            state_d = state_t'(2'd3);
        else if (count_d != '0)  state_d = S_WRITE;
      S_WRITE, S_BLOCKED:
        if (pop_last)                          state_d = state_t'(2'd3);
        else if (hazard && count_d != '0)      state_d = S_BLOCKED;
        else if (count_d == '0 && !push)       state_d = S_IDLE;
        else                                   state_d = S_WRITE;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wr_idx_q   <= '0;
      mem_addr_q <= BASE_ADDR;
      mem_data_q <= '0;
      mem_w_en_q <= 1'b0;
      wr_count_q <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wr_idx_q   <= wr_idx_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_w_en_q <= mem_w_en_d;
      wr_count_q <= wr_count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // Buffer storage carries data only; occupancy is tracked by the reset pointers.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= qed_instr_i;
  end

  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign mem_w_en_o = mem_w_en_q;
  assign wr_count_o = wr_count_q;
  assign overflow_o = overflow_q;
`ifdef QED_IMEM_WRAP_EN
  assign done_o = 1'b0;
`else
  assign done_o = done_q;
`endif

endmodule

// File: tb/tb_qed_imem_writer.sv
// Directed bench for qed_imem_writer: latency, streaming, fetch hazard, overflow,
// end-of-memory (or wrap with QED_IMEM_WRAP_EN) and mid-burst reset.
module tb_qed_imem_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        qed_vld = 1'b0;
  logic [31:0] qed_instr = '0;
  logic        qed_rdy;
  logic [31:0] fetch_addr = 32'h40;
  logic [31:0] mem_addr, mem_data, wr_count;
  logic        mem_w_en, overflow, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qed_imem_writer dut (
    .clk_i(clk), .rst_i(rst), .qed_vld_i(qed_vld), .qed_instr_i(qed_instr),
    .qed_rdy_o(qed_rdy), .fetch_addr_i(fetch_addr), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .mem_w_en_o(mem_w_en), .wr_count_o(wr_count),
    .overflow_o(overflow), .done_o(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    qed_vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    fetch_addr = 32'h40;
    do_reset();
    chk("rst_wen", {31'd0, mem_w_en}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_data", mem_data, 32'h0);
    chk("rst_cnt", wr_count, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdy", {31'd0, qed_rdy}, 32'd1);

    // Single word latency
    tick();
    qed_vld = 1'b1; qed_instr = 32'h0000_0013;
    tick();
    qed_vld = 1'b0;
    chk("lat_wen0", {31'd0, mem_w_en}, 32'd0);
    tick();
    chk("lat_wen1", {31'd0, mem_w_en}, 32'd1);
    chk("lat_addr", mem_addr, 32'h0);
    chk("lat_data", mem_data, 32'h13);
    chk("lat_cnt", wr_count, 32'd1);
    tick();
    chk("lat_wen2", {31'd0, mem_w_en}, 32'd0);

    // Six words back-to-back
    do_reset();
    for (int i = 0; i <= 6; i++) begin
      qed_vld = (i < 6);
      qed_instr = 32'h100 + i;
      tick();
      if (i > 0) begin
        chk("b2b_wen", {31'd0, mem_w_en}, 32'd1);
        chk("b2b_addr", mem_addr, 32'((i - 1) * 4));
        chk("b2b_data", mem_data, 32'h100 + 32'(i - 1));
      end
    end
    qed_vld = 1'b0;
    tick();
    chk("b2b_idle", {31'd0, mem_w_en}, 32'd0);
    chk("b2b_cnt", wr_count, 32'd6);
    chk("b2b_ovf", {31'd0, overflow}, 32'd0);

    // Hazard on word 2
    do_reset();
    fetch_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      qed_vld = 1'b1; qed_instr = 32'hA0 + i;
      tick();
      if (i == 1) begin chk("hz_a_addr", mem_addr, 32'h0); chk("hz_a_data", mem_data, 32'hA0); end
      if (i == 2) begin chk("hz_b_addr", mem_addr, 32'h4); chk("hz_b_data", mem_data, 32'hA1); end
    end
    qed_vld = 1'b0;
    tick();
    chk("hz_hold_wen", {31'd0, mem_w_en}, 32'd0);
    tick();
    chk("hz_hold_wen2", {31'd0, mem_w_en}, 32'd0);
    chk("hz_hold_addr", mem_addr, 32'h4);
    fetch_addr = 32'h20;
    tick();
    chk("hz_c_wen", {31'd0, mem_w_en}, 32'd1);
    chk("hz_c_addr", mem_addr, 32'h8);
    chk("hz_c_data", mem_data, 32'hA2);

    // Permanent hazard, overflow on 5th word
    do_reset();
    fetch_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      qed_vld = 1'b1; qed_instr = 32'hB0 + i;
      if (i == 4) chk("ovf_rdy", {31'd0, qed_rdy}, 32'd0);
      tick();
      chk("ovf_nowr", {31'd0, mem_w_en}, 32'd0);
    end
    qed_vld = 1'b0;
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_cnt", wr_count, 32'd0);
    tick();
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Fill the whole memory
    do_reset();
    for (int i = 0; i <= 32; i++) begin
      fetch_addr = (i < 16) ? 32'h40 : 32'h0;
      qed_vld = (i < 32);
      qed_instr = 32'hC00 + i;
      tick();
      if (i > 0) begin
        chk("full_wen", {31'd0, mem_w_en}, 32'd1);
        chk("full_addr", mem_addr, 32'((i - 1) * 4));
      end
    end
    chk("full_cnt", wr_count, 32'd32);
    chk("full_data", mem_data, 32'hC1F);
    fetch_addr = 32'h40;
`ifdef QED_IMEM_WRAP_EN
    chk("wrap_done", {31'd0, done}, 32'd0);
    qed_vld = 1'b1; qed_instr = 32'hD33;
    tick();
    qed_vld = 1'b0;
    tick();
    chk("wrap_wen", {31'd0, mem_w_en}, 32'd1);
    chk("wrap_addr", mem_addr, 32'h0);
    chk("wrap_data", mem_data, 32'hD33);
`else
    chk("done_flag", {31'd0, done}, 32'd1);
    chk("done_rdy", {31'd0, qed_rdy}, 32'd0);
    qed_vld = 1'b1; qed_instr = 32'hD33;
    tick();
    qed_vld = 1'b0;
    tick();
    chk("done_nowr", {31'd0, mem_w_en}, 32'd0);
    chk("done_ovf", {31'd0, overflow}, 32'd1);
    chk("done_cnt", wr_count, 32'd32);
`endif

    // Reset with entries queued
    do_reset();
    fetch_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      qed_vld = 1'b1; qed_instr = 32'hE0 + i;
      tick();
    end
    qed_vld = 1'b0;
    fetch_addr = 32'h40;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_wen0", {31'd0, mem_w_en}, 32'd0);
    tick();
    chk("mrst_wen1", {31'd0, mem_w_en}, 32'd0);
    chk("mrst_cnt", wr_count, 32'd0);
    qed_vld = 1'b1; qed_instr = 32'hF00D;
    tick();
    qed_vld = 1'b0;
    tick();
    chk("mrst_wen2", {31'd0, mem_w_en}, 32'd1);
    chk("mrst_addr", mem_addr, 32'h0);
    chk("mrst_data", mem_data, 32'hF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
